pipelined_addsub: RTL and testbench

//  Parametrised, pipelined add/subtract unit; successor of the fixed 32-bit ripple adder in the ALU.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/addsub_seg.sv | 34 +++
 rtl/pipelined_addsub.sv | 151 +++++++++++++++
 tb/tb_pipelined_addsub.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: default datapath geometry, add/sub opcode encoding
// and the helper that derives the number of pipeline segments.
package alu_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_SEG_W = 8;

  // Operation select as seen on the 'sub' input of the add/sub unit.
  typedef enum logic {
    ALU_OP_ADD = 1'b0,
    ALU_OP_SUB = 1'b1
  } alu_op_e;

  // Number of SEG_W-bit segments in a WIDTH-bit word; clamped to 1 so that an
  // illegal parameter set still elaborates far enough to report its own error.
  function automatic int calc_nseg(input int width, input int seg_w);
    if (seg_w < 1) return 1;
    if (width / seg_w < 1) return 1;
    return width / seg_w;
  endfunction

endpackage

// File: rtl/addsub_seg.sv
// One SEG_W-bit slice of the add/sub datapath. Purely combinational; exposes
// the carry into its MSB so the top segment can form the signed-overflow flag.
module addsub_seg #(
  parameter int SEG_W = 8
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             ci,
  output logic [SEG_W-1:0] s,
  output logic             co,
  output logic             cmsb
);

  if (SEG_W == 1) begin : g_bit
    // Single-bit slice: the carry into the MSB is the slice carry-in itself.
    always_comb begin
      cmsb = ci;
      s    = a ^ b ^ ci;
      co   = (a[0] & b[0]) | (ci & (a[0] ^ b[0]));
    end
  end else begin : g_wide
    logic [SEG_W-1:0] low;

    // Add the bits below the MSB first so their carry-out (the carry into the
    // MSB) is visible, then finish the MSB with a full-adder equation.
    always_comb begin
      low  = {1'b0, a[SEG_W-2:0]} + {1'b0, b[SEG_W-2:0]} + {{(SEG_W-1){1'b0}}, ci};
      cmsb = low[SEG_W-1];
      s    = {a[SEG_W-1] ^ b[SEG_W-1] ^ low[SEG_W-1], low[SEG_W-2:0]};
      co   = (a[SEG_W-1] & b[SEG_W-1]) | (low[SEG_W-1] & (a[SEG_W-1] ^ b[SEG_W-1]));
    end
  end

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract unit. Operands are split into SEG_W-bit segments and
// one segment is added per stage; operand segments not yet consumed ride along
// in skew registers, completed sum segments ride along until the last stage.
// A global stall (result valid but not taken) freezes every stage, so the
// latency is fixed at NSEG cycles and throughput is one beat per cycle.
module pipelined_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SEG_W = DEFAULT_SEG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovflw,
  output logic             zero
);

  localparam int NSEG = calc_nseg(WIDTH, SEG_W);

  // Reject geometries the segment split cannot represent.
  if (SEG_W < 1) begin : g_bad_seg
    $error("pipelined_addsub: SEG_W (%0d) must be at least 1", SEG_W);
  end else if (WIDTH % SEG_W != 0) begin : g_bad_width
    $error("pipelined_addsub: WIDTH (%0d) must be a multiple of SEG_W (%0d)", WIDTH, SEG_W);
  end

  alu_op_e          op;
  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic             stall;
  logic             accept;
  logic             ovf_q;
  logic             zero_q;

  // Subtraction is a + ~b + ~cin, i.e. invert b and the carry-in at entry.
  assign op     = alu_op_e'(sub);
  assign b_eff  = (op == ALU_OP_SUB) ? ~b : b;
  assign c0     = cin ^ (op == ALU_OP_SUB);

  // A result that is not taken blocks the whole pipe, including the input.
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready;

  for (genvar j = 0; j < NSEG; j++) begin : g_stage
    // Width of the not-yet-consumed b_eff slice arriving at this stage; the
    // segment added here sits at its bottom.
    localparam int IN_W = WIDTH - j * SEG_W;

    logic             v_in;
    logic             c_in;
    logic [WIDTH-1:0] x_in;   // completed sum segments below j, a segments from j up
    logic [IN_W-1:0]  bs_in;
    logic [WIDTH-1:0] x_nxt;
    logic [SEG_W-1:0] seg_sum;
    logic             seg_co;
    logic             seg_cmsb;
    logic             v_q;
    logic             c_q;
    logic [WIDTH-1:0] x_q;

    if (j == 0) begin : g_src
      assign v_in  = accept;
      assign c_in  = c0;
      assign x_in  = a;
      assign bs_in = b_eff;
    end else begin : g_src
      assign v_in  = g_stage[j-1].v_q;
      assign c_in  = g_stage[j-1].c_q;
      assign x_in  = g_stage[j-1].x_q;
      assign bs_in = g_stage[j-1].g_fwd.bs_q;
    end

    addsub_seg #(
      .SEG_W (SEG_W)
    ) u_seg (
      .a    (x_in[j*SEG_W +: SEG_W]),
      .b    (bs_in[SEG_W-1:0]),
      .ci   (c_in),
      .s    (seg_sum),
      .co   (seg_co),
      .cmsb (seg_cmsb)
    );

    // Replace operand segment j with its freshly computed sum segment.
    always_comb begin
      // NOTE: assign the full default first so every path writes every bit and
      // no latch is inferred; the part-select override then wins.
      x_nxt = x_in;
      x_nxt[j*SEG_W +: SEG_W] = seg_sum;
    end

    // Stage register: valid, carry out of segment j and the mixed sum/operand word.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        // NOTE: the wide data registers are reset too, not only the valid
        // bits, so outputs are deterministic (zero) before the first result.
        v_q <= 1'b0;
        c_q <= 1'b0;
        x_q <= '0;
      end else if (!stall) begin
        // NOTE: non-blocking assignments so every stage samples the previous
        // stage's old value on the same edge.
        v_q <= v_in;
        c_q <= seg_co;
        x_q <= x_nxt;
      end
    end

    if (j < NSEG - 1) begin : g_fwd
      logic [IN_W-SEG_W-1:0] bs_q;

      // Skew register: pass the b_eff segments still to be added downstream.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          bs_q <= '0;
        end else if (!stall) begin
          bs_q <= bs_in[IN_W-1:SEG_W];
        end
      end
    end else begin : g_flags
      // Flag registers, captured together with the final sum segment.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (!stall) begin
          ovf_q  <= seg_cmsb ^ seg_co;
          zero_q <= (x_nxt == '0);
        end
      end
    end
  end

  assign out_valid = g_stage[NSEG-1].v_q;
  assign sum       = g_stage[NSEG-1].x_q;
  assign cout      = g_stage[NSEG-1].c_q;
  assign ovflw     = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: a 32/8 instance (latency 4) and a 16/16 instance
// (latency 1). Drivers push expected results into per-instance queues; a monitor
// per instance pops and compares whenever a result is presented.
module tb_pipelined_addsub;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } exp32_t;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } exp16_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    exp32_t      exp;
  } vec32_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    exp16_t      exp;
  } vec16_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  // 32-bit, 8-bit segment instance
  logic        in_valid0, in_ready0, cin0, sub0, out_valid0, out_ready0;
  logic [31:0] a0, b0, sum0;
  logic        cout0, ovf0, zero0;

  // 16-bit, single segment instance
  logic        in_valid1, in_ready1, cin1, sub1, out_valid1, out_ready1;
  logic [15:0] a1, b1, sum1;
  logic        cout1, ovf1, zero1;

  pipelined_addsub #(.WIDTH(32), .SEG_W(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .a(a0), .b(b0), .cin(cin0), .sub(sub0), .out_valid(out_valid0),
    .out_ready(out_ready0), .sum(sum0), .cout(cout0), .ovflw(ovf0), .zero(zero0)
  );

  pipelined_addsub #(.WIDTH(16), .SEG_W(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1), .sub(sub1), .out_valid(out_valid1),
    .out_ready(out_ready1), .sum(sum1), .cout(cout1), .ovflw(ovf1), .zero(zero1)
  );

  int     n_checks = 0;
  int     n_fail   = 0;
  exp32_t q0[$];
  exp16_t q1[$];
  logic   toggle_done;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec32_t mk32(input logic [31:0] a, input logic [31:0] b, input logic cin,
                                  input logic sub, input logic [31:0] s, input logic co,
                                  input logic ov, input logic z);
    vec32_t v;
    v.a = a; v.b = b; v.cin = cin; v.sub = sub;
    v.exp.sum = s; v.exp.cout = co; v.exp.ovf = ov; v.exp.zero = z;
    return v;
  endfunction

  function automatic vec16_t mk16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                                  input logic sub, input logic [15:0] s, input logic co,
                                  input logic ov, input logic z);
    vec16_t v;
    v.a = a; v.b = b; v.cin = cin; v.sub = sub;
    v.exp.sum = s; v.exp.cout = co; v.exp.ovf = ov; v.exp.zero = z;
    return v;
  endfunction

  // Reference model: unsigned arithmetic for sum/carry/borrow, exact signed
  // arithmetic for the overflow flag.
  function automatic vec32_t model32(input logic [31:0] a, input logic [31:0] b,
                                     input logic cin, input logic sub);
    logic [32:0] u;
    longint      s;
    vec32_t      v;
    if (!sub) begin
      u = {1'b0, a} + {1'b0, b} + {32'd0, cin};
      s = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
    end else begin
      u = {1'b0, a} - {1'b0, b} - {32'd0, cin};
      s = longint'($signed(a)) - longint'($signed(b)) - longint'(cin);
    end
    v = mk32(a, b, cin, sub, u[31:0], sub ? ~u[32] : u[32],
             (s > 64'sd2147483647) || (s < -64'sd2147483648), u[31:0] == 32'd0);
    return v;
  endfunction

  function automatic vec32_t rand32();
    return model32($urandom(), $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endfunction

  // Drive one beat (called at posedge+1), wait for acceptance, record expectation.
  task automatic send0(input vec32_t v);
    int k;
    a0 = v.a; b0 = v.b; cin0 = v.cin; sub0 = v.sub; in_valid0 = 1'b1;
    k = 0;
    @(negedge clk);
    while (!in_ready0 && k < 100) begin
      k++;
      @(negedge clk);
    end
    if (!in_ready0) check("dut0 in_ready timeout", {63'd0, in_ready0}, 64'd1);
    else q0.push_back(v.exp);
    @(posedge clk);
    #1;
    in_valid0 = 1'b0;
  endtask

  task automatic send1(input vec16_t v);
    int k;
    a1 = v.a; b1 = v.b; cin1 = v.cin; sub1 = v.sub; in_valid1 = 1'b1;
    k = 0;
    @(negedge clk);
    while (!in_ready1 && k < 100) begin
      k++;
      @(negedge clk);
    end
    if (!in_ready1) check("dut1 in_ready timeout", {63'd0, in_ready1}, 64'd1);
    else q1.push_back(v.exp);
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((q0.size() != 0 || q1.size() != 0) && k < 300) begin
      k++;
      @(negedge clk);
    end
    check("drain pending results", 64'(q0.size() + q1.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor for the 32-bit instance: compare on transfer, check hold on stall.
  always @(negedge clk) begin
    if (rst_n && out_valid0) begin
      if (q0.size() == 0) begin
        check("dut0 unexpected out_valid", {63'd0, out_valid0}, 64'd0);
      end else if (out_ready0) begin
        check("dut0 result", 64'({sum0, cout0, ovf0, zero0}), 64'(q0[0]));
        void'(q0.pop_front());
      end else begin
        check("dut0 held result", 64'({sum0, cout0, ovf0, zero0}), 64'(q0[0]));
        check("dut0 in_ready during stall", {63'd0, in_ready0}, 64'd0);
      end
    end
  end

  // Monitor for the 16-bit instance.
  always @(negedge clk) begin
    if (rst_n && out_valid1) begin
      if (q1.size() == 0) begin
        check("dut1 unexpected out_valid", {63'd0, out_valid1}, 64'd0);
      end else if (out_ready1) begin
        check("dut1 result", 64'({sum1, cout1, ovf1, zero1}), 64'(q1[0]));
        void'(q1.pop_front());
      end
    end
  end

  vec32_t dir32[12];
  vec16_t dir16[4];

  initial begin
    in_valid0 = 1'b0; a0 = '0; b0 = '0; cin0 = 1'b0; sub0 = 1'b0; out_ready0 = 1'b1;
    in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0; out_ready1 = 1'b1;
    toggle_done = 1'b0;

    //                a             b             cin   sub   sum           co    ov    z
    dir32[0]  = mk32(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
    dir32[1]  = mk32(32'h00000005, 32'h00000005, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1);
    dir32[2]  = mk32(32'h00000000, 32'h00000001, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    dir32[3]  = mk32(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
    dir32[4]  = mk32(32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
    dir32[5]  = mk32(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0);
    dir32[6]  = mk32(32'h00FFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h01000000, 1'b0, 1'b0, 1'b0);
    dir32[7]  = mk32(32'h12345678, 32'h87654321, 1'b1, 1'b0, 32'h9999999A, 1'b0, 1'b0, 1'b0);
    dir32[8]  = mk32(32'h0000000A, 32'h00000003, 1'b1, 1'b1, 32'h00000006, 1'b1, 1'b0, 1'b0);
    dir32[9]  = mk32(32'h00000000, 32'h00000000, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    dir32[10] = mk32(32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1);
    dir32[11] = mk32(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b1, 1'b0);

    dir16[0]  = mk16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    dir16[1]  = mk16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    dir16[2]  = mk16(16'h0005, 16'h0005, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    dir16[3]  = mk16(16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset dut0 out_valid", {63'd0, out_valid0}, 64'd0);
    check("reset dut0 outputs", 64'({sum0, cout0, ovf0, zero0}), 64'd0);
    check("reset dut1 out_valid", {63'd0, out_valid1}, 64'd0);
    check("reset dut1 outputs", 64'({sum1, cout1, ovf1, zero1}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("dut0 in_ready after reset", {63'd0, in_ready0}, 64'd1);
    check("dut1 in_ready after reset", {63'd0, in_ready1}, 64'd1);
    @(posedge clk);
    #1;

    // Directed vectors, back to back
    for (int i = 0; i < 12; i++) send0(dir32[i]);
    drain();

    // 100 back-to-back random beats with the sink always ready
    for (int i = 0; i < 100; i++) send0(rand32());
    drain();

    // Fill the pipe with the sink blocked, hold the stall, then release
    out_ready0 = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send0(rand32());
      end
      begin
        int k;
        k = 0;
        @(negedge clk);
        while (!out_valid0 && k < 50) begin
          k++;
          @(negedge clk);
        end
        check("dut0 out_valid while filling", {63'd0, out_valid0}, 64'd1);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1;
        out_ready0 = 1'b1;
      end
    join
    drain();

    // Random back-pressure on a random stream
    fork
      begin
        for (int i = 0; i < 30; i++) send0(rand32());
        toggle_done = 1'b1;
      end
      begin
        while (!toggle_done) begin
          @(posedge clk);
          #1;
          out_ready0 = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready0 = 1'b1;
    drain();

    // Reset with one beat at the output and three more in flight
    for (int i = 0; i < 4; i++) send0(rand32());
    rst_n = 1'b0;
    #1;
    check("dut0 out_valid on reset", {63'd0, out_valid0}, 64'd0);
    check("dut0 in_ready on reset", {63'd0, in_ready0}, 64'd1);
    q0.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    send0(dir32[0]);
    send0(dir32[7]);
    drain();

    // Single-segment instance (registered, latency 1)
    for (int i = 0; i < 4; i++) send1(dir16[i]);
    drain();

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
